// File: rtl/uart_pkg.sv
// Types and constants shared by the UART stream blocks (transmitter now,
// receiver later).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

endpackage

// File: rtl/uart_stream_tx_if.sv
// Word stream port feeding the UART transmitter.
// Handshake: a word moves on every clk edge where s_valid && s_ready; the
// producer may change s_data freely while s_valid is low.
interface uart_stream_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and a combinational read head.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_sync_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    // Same address bits with differing wrap bits means the writer lapped the reader.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_stream_tx.sv
// UART transmitter: buffers words from a valid/ready stream and sends them as
// start / LSB-first data / optional parity / stop frames, one bit per baud_tick.
module uart_stream_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    baud_tick,
    uart_stream_tx_if.slave         s_if,
    output logic                    tx,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(DEPTH):0]  level,
    output tx_state_t               dbg_state
);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_stream_tx: DATA_BITS must be 5..8");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("uart_stream_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_stream_tx: STOP_BITS must be 1..2");
    end

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_full, fifo_empty, pop, head_par;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (s_if.s_valid),
        .wr_data (s_if.s_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Parity is taken from the head word at pop time, before the shifter consumes it.
    assign head_par = (PARITY == PAR_ODD) ? ~(^fifo_head) : (^fifo_head);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        if (baud_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        par_d   = head_par;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_idx_q < LAST_BIT) begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else if (PARITY != PAR_NONE) begin
                        tx_d    = par_q;
                        state_d = ST_PARITY;
                    end else begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = ST_STOP;
                    end
                end
                ST_PARITY: begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_STOP;
                end
                ST_STOP: begin
                    if (stop_cnt_q < LAST_STOP) begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end else begin
                        done_d = 1'b1;
                        // Chain straight into the next start bit when more words wait.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_head;
                            par_d   = head_par;
                            tx_d    = 1'b0;
                            state_d = ST_START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign s_if.s_ready = ~fifo_full;
    assign tx           = tx_q;
    assign done         = done_q;
    assign busy         = (state_q != ST_IDLE) || !fifo_empty;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_stream_tx.sv
// Directed bench for uart_stream_tx: four configurations (8N1, 7E2, 7O2,
// 8N1 with a 4-deep FIFO) share clock, reset and baud_tick.
module tb_uart_stream_tx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_tick;
    logic [7:0] drv_data;
    logic [3:0] drv_valid;

    logic [3:0] tx_w, busy_w, done_w, ready_w;
    logic [3:0] lvl_a, lvl_b, lvl_c;
    logic [2:0] lvl_d;
    tx_state_t  st_a, st_b, st_c, st_d;

    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];

    typedef struct {
        int          sel;
        logic [7:0]  data;
        int          len;
        logic [15:0] exp_bits;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    uart_stream_tx_if #(.DATA_BITS(8)) if_a ();
    uart_stream_tx_if #(.DATA_BITS(7)) if_b ();
    uart_stream_tx_if #(.DATA_BITS(7)) if_c ();
    uart_stream_tx_if #(.DATA_BITS(8)) if_d ();

    assign if_a.s_data  = drv_data;
    assign if_b.s_data  = drv_data[6:0];
    assign if_c.s_data  = drv_data[6:0];
    assign if_d.s_data  = drv_data;
    assign if_a.s_valid = drv_valid[0];
    assign if_b.s_valid = drv_valid[1];
    assign if_c.s_valid = drv_valid[2];
    assign if_d.s_valid = drv_valid[3];
    assign ready_w      = {if_d.s_ready, if_c.s_ready, if_b.s_ready, if_a.s_ready};

    uart_stream_tx #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .DEPTH(8)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .s_if(if_a),
        .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]), .level(lvl_a), .dbg_state(st_a)
    );
    uart_stream_tx #(.DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(2), .DEPTH(8)) u_7e2 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .s_if(if_b),
        .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]), .level(lvl_b), .dbg_state(st_b)
    );
    uart_stream_tx #(.DATA_BITS(7), .PARITY(PAR_ODD), .STOP_BITS(2), .DEPTH(8)) u_7o2 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .s_if(if_c),
        .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]), .level(lvl_c), .dbg_state(st_c)
    );
    uart_stream_tx #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .DEPTH(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .s_if(if_d),
        .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]), .level(lvl_d), .dbg_state(st_d)
    );

    function automatic logic [31:0] get_level(input int sel);
        case (sel)
            0:       return 32'(lvl_a);
            1:       return 32'(lvl_b);
            2:       return 32'(lvl_c);
            default: return 32'(lvl_d);
        endcase
    endfunction

    function automatic logic [9:0] frame_8n1(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One baud tick lands on the posedge between the two negedges; outputs are
    // sampled at the second negedge.
    task automatic tick();
        @(negedge clk);
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
    endtask

    task automatic push(input int sel, input logic [7:0] d);
        @(negedge clk);
        drv_data       = d;
        drv_valid[sel] = 1'b1;
        @(negedge clk);
        drv_valid[sel] = 1'b0;
    endtask

    task automatic enqueue_frame(input logic [7:0] d, input int from_bit);
        logic [9:0] f;
        f = frame_8n1(d);
        for (int i = from_bit; i < 10; i++) exp_q.push_back(f[i]);
    endtask

    task automatic drain(input int sel, input string name, output int done_cnt);
        logic [0:0] e;
        done_cnt = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tick();
            check(name, 32'(tx_w[sel]), 32'(e));
            if (done_w[sel]) done_cnt++;
        end
    endtask

    initial begin
        int   dcnt;
        logic seen_done, seen_low;

        vecs[0] = '{0, 8'h50, 10, 16'h02A0};
        vecs[1] = '{0, 8'h0A, 10, 16'h0214};
        vecs[2] = '{0, 8'hFF, 10, 16'h03FE};
        vecs[3] = '{1, 8'h4F, 11, 16'h079E};
        vecs[4] = '{1, 8'h00, 11, 16'h0600};
        vecs[5] = '{2, 8'h4F, 11, 16'h069E};
        vecs[6] = '{2, 8'h00, 11, 16'h0700};
        vecs[7] = '{3, 8'h81, 10, 16'h0302};

        rst_n     = 1'b0;
        baud_tick = 1'b0;
        drv_data  = 8'h00;
        drv_valid = 4'h0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx_w), 32'hF);
        check("reset_busy", 32'(busy_w), 32'h0);
        check("reset_done", 32'(done_w), 32'h0);
        check("reset_ready", 32'(ready_w), 32'hF);
        check("reset_level", get_level(0), 0);
        check("reset_state", 32'(st_a), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        repeat (3) begin
            tick();
            check("stray_tx", 32'(tx_w), 32'hF);
            check("stray_busy", 32'(busy_w), 32'h0);
            check("stray_done", 32'(done_w), 32'h0);
        end

        for (int v = 0; v < 8; v++) begin
            int s;
            s = vecs[v].sel;
            push(s, vecs[v].data);
            check($sformatf("vec%0d_level_push", v), get_level(s), 1);
            check($sformatf("vec%0d_busy_push", v), 32'(busy_w[s]), 1);
            for (int i = 0; i < vecs[v].len; i++) begin
                tick();
                check($sformatf("vec%0d_tx_bit%0d", v, i), 32'(tx_w[s]), 32'(vecs[v].exp_bits[i]));
            end
            tick();
            check($sformatf("vec%0d_end_tx", v), 32'(tx_w[s]), 1);
            check($sformatf("vec%0d_end_done", v), 32'(done_w[s]), 1);
            check($sformatf("vec%0d_end_busy", v), 32'(busy_w[s]), 0);
            check($sformatf("vec%0d_end_level", v), get_level(s), 0);
            @(negedge clk);
            check($sformatf("vec%0d_done_width", v), 32'(done_w[s]), 0);
        end

        // Push and tick on the same edge: the word cannot start until the next tick.
        @(negedge clk);
        drv_data     = 8'h0A;
        drv_valid[0] = 1'b1;
        baud_tick    = 1'b1;
        @(negedge clk);
        drv_valid[0] = 1'b0;
        baud_tick    = 1'b0;
        check("same_cycle_tx", 32'(tx_w[0]), 1);
        check("same_cycle_level", get_level(0), 1);
        check("same_cycle_busy", 32'(busy_w[0]), 1);
        enqueue_frame(8'h0A, 0);
        drain(0, "same_cycle_stream", dcnt);
        check("same_cycle_early_done", 32'(dcnt), 0);
        tick();
        check("same_cycle_done", 32'(done_w[0]), 1);

        // "POLO\n" back to back.
        push(0, 8'h50);
        push(0, 8'h4F);
        push(0, 8'h4C);
        push(0, 8'h4F);
        push(0, 8'h0A);
        check("b2b_level", get_level(0), 5);
        enqueue_frame(8'h50, 0);
        enqueue_frame(8'h4F, 0);
        enqueue_frame(8'h4C, 0);
        enqueue_frame(8'h4F, 0);
        enqueue_frame(8'h0A, 0);
        drain(0, "b2b_stream", dcnt);
        tick();
        check("b2b_done_count", 32'(dcnt + int'(done_w[0])), 5);
        check("b2b_end_busy", 32'(busy_w[0]), 0);
        check("b2b_end_tx", 32'(tx_w[0]), 1);

        // Four-deep FIFO: fill, overflow attempt, one pop, push again.
        push(3, 8'h11);
        check("full_ready1", 32'(ready_w[3]), 1);
        push(3, 8'h22);
        check("full_ready2", 32'(ready_w[3]), 1);
        push(3, 8'h33);
        check("full_ready3", 32'(ready_w[3]), 1);
        push(3, 8'h44);
        check("full_ready4", 32'(ready_w[3]), 0);
        check("full_level4", get_level(3), 4);
        push(3, 8'h55);
        check("full_drop_level", get_level(3), 4);
        tick();
        check("full_pop_tx", 32'(tx_w[3]), 0);
        check("full_pop_level", get_level(3), 3);
        check("full_pop_ready", 32'(ready_w[3]), 1);
        push(3, 8'h66);
        check("full_refill_level", get_level(3), 4);
        enqueue_frame(8'h11, 1);
        enqueue_frame(8'h22, 0);
        enqueue_frame(8'h33, 0);
        enqueue_frame(8'h44, 0);
        enqueue_frame(8'h66, 0);
        drain(3, "full_stream", dcnt);
        tick();
        check("full_done_count", 32'(dcnt + int'(done_w[3])), 5);
        check("full_end_busy", 32'(busy_w[3]), 0);
        check("full_end_level", get_level(3), 0);

        // Reset in the middle of the data bits with another word queued.
        push(0, 8'h00);
        push(0, 8'h55);
        repeat (4) tick();
        check("rst_pre_tx", 32'(tx_w[0]), 0);
        check("rst_pre_state", 32'(st_a), 32'(ST_DATA));
        check("rst_pre_level", get_level(0), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_tx", 32'(tx_w[0]), 1);
        check("rst_level", get_level(0), 0);
        check("rst_busy", 32'(busy_w[0]), 0);
        check("rst_done", 32'(done_w[0]), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        seen_done = 1'b0;
        seen_low  = 1'b0;
        repeat (12) begin
            tick();
            if (done_w[0]) seen_done = 1'b1;
            if (!tx_w[0]) seen_low = 1'b1;
        end
        check("post_rst_done_seen", 32'(seen_done), 0);
        check("post_rst_tx_low_seen", 32'(seen_low), 0);
        check("post_rst_busy", 32'(busy_w[0]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_stream_tx.md
# uart_stream_tx

Parametrised UART transmitter that serialises a stream of words from a valid/ready input port, buffering them in an internal FIFO. Data width, parity mode, stop-bit count and FIFO depth are all parameters. It sits between any byte producer (message sequencer, command responder) and the `tx` pin. It shares the system-wide one-tick-per-bit `baud_tick` strobe with the other UART blocks.

## Interface
Parameters:
- `DATA_BITS`, 8: word width, legal 5..8.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: number of stop bits, legal 1..2.
- `DEPTH`, 8: FIFO entries, power of 2, at least 2.

Ports:
- `clk  in  1`: system clock. One clock domain only.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `baud_tick  in  1`: one-`clk` strobe, one per bit period.
- `s_data  in  DATA_BITS`: word to send.
- `s_valid  in  1`: `s_data` is valid.
- `s_ready  out  1`: FIFO can accept a word. Equals `!full`.
- `tx  out  1`: serial line. Idle level is high.
- `busy  out  1`: high when a frame is in progress or the FIFO is non-empty.
- `done  out  1`: one-`clk` pulse at the end of each frame.
- `level  out  $clog2(DEPTH)+1`: current FIFO occupancy.

## Operation
- **Push:** a word is pushed when `s_valid && s_ready` on a `clk` edge. When the FIFO is full, `s_ready` is 0 and `s_data` is ignored.
- **Frame format:** start bit (0), then `DATA_BITS` data bits LSB first, then an optional parity bit, then `STOP_BITS` stop bits (1).
- **Parity bit:**
  - Odd mode: XNOR-reduce of the data, so the total count of ones over data plus parity is odd.
  - Even mode: XOR-reduce of the data.
- **State machine:** IDLE, START, DATA, PARITY, STOP. Transitions happen only on `clk` edges where `baud_tick` = 1. `tx` is registered and updated on the same edge as the state.
  - IDLE, FIFO non-empty: pop the head word into the shift register; `tx` ← 0; go to START.
  - START: `tx` ← data bit 0; `bit_idx` ← 0; go to DATA.
  - DATA, `bit_idx` < `DATA_BITS`-1: `tx` ← next data bit; increment `bit_idx`.
  - DATA, last bit done: `tx` ← parity bit and go to PARITY if `PARITY` ≠ 0. Otherwise `tx` ← 1, `stop_cnt` ← 0, go to STOP.
  - PARITY: `tx` ← 1; `stop_cnt` ← 0; go to STOP.
  - STOP, `stop_cnt` < `STOP_BITS`-1: increment `stop_cnt`; `tx` stays 1.
  - STOP, last stop bit: pulse `done`. If the FIFO is non-empty, pop the next word, `tx` ← 0, go to START (back-to-back, no idle bit). Otherwise `tx` ← 1, go to IDLE.
- **Pop/push ordering:** a pop uses registered FIFO state only. A word pushed in the same cycle the FIFO is empty cannot be popped until the next tick.
- **Push while full:** when full, a push in the same cycle as a pop is not accepted, because `s_ready` was 0.

## Timing
- **Reset values:** `tx` = 1, `busy` = 0, `done` = 0, `s_ready` = 1, `level` = 0, state = IDLE, FIFO empty.
- **Frame length:** 1 + `DATA_BITS` + (`PARITY` ≠ 0) + `STOP_BITS` ticks.
- **Start latency:** the start bit appears on the first `baud_tick` edge after the word is registered in the FIFO. That is at least one `clk` after the push edge.
- **Occupancy:** `level` changes by +1 on a push, −1 on a pop, and 0 when both happen in the same cycle.
- **`busy`:** deasserts in the same cycle that state returns to IDLE with the FIFO empty.
- **Reset mid-frame:**
  - `tx` returns to 1 asynchronously.
  - The FIFO contents and the partial frame are discarded.
  - No `done` pulse is produced.
- **`baud_tick` outside a frame:** a tick while idle with an empty FIFO has no effect.

## Structure
- **Package `uart_pkg`:**
  - Enum `tx_state_t` with the states above.
  - Parity constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`.
  - Shared with the future `uart_stream_rx`.
- **Sub-module `uart_sync_fifo` (parameters WIDTH, DEPTH):**
  - Pointers are one bit wider than the address to distinguish full from empty.
  - Outputs: `full`, `empty`, `level`.
  - The read head is combinational.
- **Parameter checks:** elaboration-time assertions on all legal ranges.

## Test plan
- **8N1, one word:** push 0x50, tick continuously → `tx` = 0, 0,0,0,0,1,0,1,0, 1 across 10 ticks, then a single `done` pulse and `busy` = 0.
- **7E2:** push 0x4F → data bits 1,1,1,1,0,0,1, parity bit 1, two stop bits, 11 ticks in total. Repeat in odd mode → parity bit 0.
- **Back-to-back:** push "POLO\n" (0x50 0x4F 0x4C 0x4F 0x0A) with `DEPTH` = 8 → 50 consecutive ticks with no idle bit, 5 `done` pulses, order preserved.
- **FIFO full:** `DEPTH` = 4, push 5 words with no ticks → `s_ready` falls after the 4th push, `level` = 4, the 5th word is dropped. One frame completes, then a push is accepted.
- **Reset mid-frame:** assert `rst_n` = 0 during DATA → `tx` = 1 immediately, `level` = 0, no `done`. After release, the line stays idle until a new push.
- **Stray ticks:** ticks while idle and empty → `tx` stays 1, `busy` and `done` stay 0.
